// File: rtl/display_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : display_scan_ctrl_if
// Description : Signal bundle between the timer/BCD datapath and the 7-segment
//               scan controller (inputs to the scanner, pin-level outputs).
// Revision    : 1.0 - initial release
// ============================================================================
interface display_scan_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  EN;
  logic [4*DIGITS-1:0]   DATA;
  logic [DIGITS-1:0]     DP;
  logic [DIGITS-1:0]     BLINK;
  logic                  LZB;
  logic [DIGITS-1:0]     SEL;
  logic [6:0]            SEG;
  logic                  SEG_DP;
  logic                  FRAME;

  // Datapath side: supplies digits and controls, observes the pins.
  modport master (
    output EN, DATA, DP, BLINK, LZB,
    input  SEL, SEG, SEG_DP, FRAME
  );

  // Scan controller side.
  modport slave (
    input  EN, DATA, DP, BLINK, LZB,
    output SEL, SEG, SEG_DP, FRAME
  );
endinterface
`default_nettype wire

// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : display_scan_ctrl
// Description : Multiplexed 7-segment scan controller. One-hot digit ring with
//               dead-time blanking, per-digit capture, BCD decode, leading-zero
//               blanking and per-digit blink. All pins are driven from flops.
// Revision    : 1.0 - initial release
// ============================================================================
module display_scan_ctrl #(
  parameter int   DIGITS    = 4,
  parameter int   SCAN_DIV  = 50000,
  parameter int   BLANK_CYC = 500,
  parameter int   BLINK_DIV = 256,
  parameter logic ACT_STATE = 1'b0
) (
  input  logic                CLK,
  input  logic                CLR,
  display_scan_ctrl_if.slave  bus
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [CW-1:0]     CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]     CNT_CAP  = CW'(BLANK_CYC - 1);
  localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
  localparam logic [BW-1:0]     BLK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [DIGITS-1:0] SEL_OFF  = {DIGITS{~ACT_STATE}};
  localparam logic [6:0]        SEG_OFF  = {7{~ACT_STATE}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [IW-1:0]   idx, idx_n;
  logic            capture;
  logic [3:0]      cap_nib, cap_nib_n;
  logic            cap_dp, cap_dp_n;
  logic            cap_lzb, cap_lzb_n;
  logic [BW-1:0]   blk_cnt;
  logic            phase;
  logic            frame_evt;
  logic [3:0]      nib [DIGITS];
  logic [DIGITS-1:0] lz;
  logic [DIGITS-1:0] sel_hot;
  logic [6:0]      seg_hi;
  logic            show_n;
  logic            blink_off;

  // Active-high segment pattern (a = bit 0); non-decimal nibbles show a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h40;
    endcase
  endfunction

  for (genvar i = 0; i < DIGITS; i++) begin : g_nib
    assign nib[i] = bus.DATA[4*i +: 4];
  end

  // lz[i] is set when digit i and every more-significant digit are zero.
  always_comb begin
    logic run;
    lz  = '0;
    run = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run   = run & (nib[i] == 4'd0);
      lz[i] = run;
    end
  end

  // Scan sequencer: next state, slot counter and digit index.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    capture = 1'b0;
    case (state)
      IDLE: begin
        if (bus.EN) begin
          state_n = BLANK;
          cnt_n   = '0;
          idx_n   = '0;
        end
      end
      BLANK: begin
        if (!bus.EN) begin
          state_n = IDLE;
          cnt_n   = '0;
          idx_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
          if (cnt == CNT_CAP) begin
            capture = 1'b1;
            state_n = SHOW;
          end
        end
      end
      SHOW: begin
        if (!bus.EN) begin
          state_n = IDLE;
          cnt_n   = '0;
          idx_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = BLANK;
          cnt_n   = '0;
          idx_n   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        idx_n   = '0;
      end
    endcase
  end

  // Capture values as they will be after this edge, so the first SHOW cycle
  // already displays the freshly captured digit.
  always_comb begin
    cap_nib_n = capture ? nib[idx] : cap_nib;
    cap_dp_n  = capture ? bus.DP[idx] : cap_dp;
    cap_lzb_n = capture ? (bus.LZB && (idx != '0) && lz[idx]) : cap_lzb;
    frame_evt = (state == SHOW) && (idx == IDX_LAST) && (cnt == CNT_LAST);
    show_n    = (state_n == SHOW);
    blink_off = phase & bus.BLINK[idx_n];
    seg_hi    = seg_decode(cap_nib_n);
    sel_hot   = '0;
    sel_hot[idx_n] = 1'b1;
  end

  // Sequencer and capture registers.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      cap_nib <= '0;
      cap_dp  <= 1'b0;
      cap_lzb <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      cap_nib <= cap_nib_n;
      cap_dp  <= cap_dp_n;
      cap_lzb <= cap_lzb_n;
    end
  end

  // Blink timebase: counts frames, holds while idle, toggles phase on wrap.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      blk_cnt <= '0;
      phase   <= 1'b0;
    end else if (frame_evt) begin
      if (blk_cnt == BLK_LAST) begin
        blk_cnt <= '0;
        phase   <= ~phase;
      end else begin
        blk_cnt <= blk_cnt + 1'b1;
      end
    end
  end

  // Pin registers; XOR with the inactive mask maps active-high to pin level.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      bus.SEL    <= SEL_OFF;
      bus.SEG    <= SEG_OFF;
      bus.SEG_DP <= ~ACT_STATE;
      bus.FRAME  <= 1'b0;
    end else begin
      bus.SEL    <= show_n ? (sel_hot ^ SEL_OFF) : SEL_OFF;
      bus.SEG    <= (show_n && !cap_lzb_n && !blink_off) ? (seg_hi ^ SEG_OFF) : SEG_OFF;
      bus.SEG_DP <= (show_n && cap_dp_n && !blink_off) ? ACT_STATE : ~ACT_STATE;
      bus.FRAME  <= frame_evt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_display_scan_ctrl
// Description : Scoreboard bench for display_scan_ctrl. Each enable run is
//               expanded by a slot-arithmetic model into expected display
//               slots and FRAME pulses; a negedge monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scan_ctrl;

  localparam int   DIGITS    = 4;
  localparam int   SCAN_DIV  = 8;
  localparam int   BLANK_CYC = 2;
  localparam int   BLINK_DIV = 2;
  localparam logic ACT_STATE = 1'b0;

  logic CLK = 1'b0;
  logic CLR = 1'b0;
  always #5 CLK = ~CLK;

  display_scan_ctrl_if #(.DIGITS(DIGITS)) bus ();

  display_scan_ctrl #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC),
    .BLINK_DIV(BLINK_DIV), .ACT_STATE(ACT_STATE)
  ) dut (
    .CLK(CLK),
    .CLR(CLR),
    .bus(bus)
  );

  typedef struct {
    int         start;
    int         len;
    logic [3:0] sel;
    logic [6:0] seg;
    logic       dp;
  } slot_t;

  slot_t slot_q[$];
  int    frame_q[$];
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_err = 0;
  int    frames_done = 0;
  bit    mon_on = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Active-high segment patterns of the digits 0..9.
  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] tbl [10];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    if (n > 4'd9) return 7'h40;
    return tbl[n];
  endfunction

  // Expand one enable run (first BLANK cycle s, L enabled cycles) into the
  // display slots and FRAME pulses it must produce.
  task automatic push_run(input int s, input int L, input logic [15:0] data,
                          input logic [3:0] dp, input logic [3:0] blink,
                          input logic lzb, input bit tail_frame);
    int nfr = 0;
    for (int t = 0; t < L; t++) begin
      int slot = t / SCAN_DIV;
      int pos  = t % SCAN_DIV;
      if (pos == BLANK_CYC) begin
        slot_t e;
        int d    = slot % DIGITS;
        int fr   = frames_done + slot / DIGITS;
        bit ph   = ((fr / BLINK_DIV) % 2) == 1;
        bit off  = ph && blink[d];
        bit blk  = lzb && (d > 0) && ((data >> (4 * d)) == 16'h0);
        logic [3:0] nb = data[4*d +: 4];
        e.start = s + t;
        e.len   = (L - t < SCAN_DIV - BLANK_CYC) ? (L - t) : (SCAN_DIV - BLANK_CYC);
        e.sel   = ~(4'b0001 << d);
        e.seg   = (off || blk) ? 7'h7F : ~seg_of(nb);
        e.dp    = (dp[d] && !off) ? 1'b0 : 1'b1;
        slot_q.push_back(e);
      end
      if (pos == SCAN_DIV - 1 && slot % DIGITS == DIGITS - 1) begin
        nfr++;
        if (tail_frame || (t + 1 < L)) frame_q.push_back(s + t + 1);
      end
    end
    frames_done += nfr;
  endtask

  task automatic run(input int L, input logic [15:0] data, input logic [3:0] dp,
                     input logic [3:0] blink, input logic lzb);
    int s;
    @(posedge CLK); #1;
    bus.DATA = data; bus.DP = dp; bus.BLINK = blink; bus.LZB = lzb;
    bus.EN = 1'b1;
    s = cyc + 1;
    push_run(s, L, data, dp, blink, lzb, 1'b1);
    repeat (L) @(posedge CLK);
    #1 bus.EN = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge CLK); #2 CLR = 1'b1;
    frames_done = 0;
    repeat (2) @(posedge CLK);
    #1 CLR = 1'b0;
  endtask

  // Monitor: pops expected slots/frames whenever the DUT presents them.
  bit         in_slot = 1'b0;
  int         run_len = 0;
  int         exp_len = 0;
  logic [3:0] cur_sel;
  logic [6:0] cur_seg;
  logic       cur_dp;
  slot_t      pe;

  always @(negedge CLK) begin
    if (mon_on) begin
      if (bus.FRAME === 1'b1) begin
        if (frame_q.size() == 0) check("frame_unexpected", cyc, 32'hFFFF_FFFF);
        else check("frame_cycle", cyc, frame_q.pop_front());
      end else if (bus.FRAME !== 1'b0) begin
        check("frame_known", {31'd0, bus.FRAME}, 32'd0);
      end
      if (bus.SEL !== 4'hF && !$isunknown(bus.SEL)) begin
        if (!in_slot) begin
          in_slot = 1'b1;
          run_len = 1;
          cur_sel = bus.SEL; cur_seg = bus.SEG; cur_dp = bus.SEG_DP;
          if (slot_q.size() == 0) begin
            exp_len = -1;
            check("slot_unexpected", cyc, 32'hFFFF_FFFF);
          end else begin
            pe = slot_q.pop_front();
            exp_len = pe.len;
            check("slot_start", cyc, pe.start);
            check("slot_sel", {28'd0, bus.SEL}, {28'd0, pe.sel});
            check("slot_seg", {25'd0, bus.SEG}, {25'd0, pe.seg});
            check("slot_dp", {31'd0, bus.SEG_DP}, {31'd0, pe.dp});
          end
        end else begin
          run_len++;
          check("slot_steady", {20'd0, bus.SEL, bus.SEG, bus.SEG_DP},
                {20'd0, cur_sel, cur_seg, cur_dp});
        end
      end else begin
        if (in_slot) begin
          check("slot_len", run_len, exp_len);
          in_slot = 1'b0;
        end
        check("idle_outputs", {20'd0, bus.SEL, bus.SEG, bus.SEG_DP},
              {20'd0, 4'hF, 7'h7F, 1'b1});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Stimulus sequence.
  initial begin
    int s;
    logic [15:0] mask [4];
    mask = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F};
    bus.EN = 1'b0; bus.DATA = '0; bus.DP = '0; bus.BLINK = '0; bus.LZB = 1'b0;
    #2 CLR = 1'b1;
    #1 mon_on = 1'b1;
    repeat (3) @(posedge CLK);
    #1 CLR = 1'b0;

    // Reset / idle with EN low.
    repeat (50) @(posedge CLK);

    // Scan order and FRAME cadence.
    run(70, 16'h4321, 4'b0100, 4'b0000, 1'b0);

    // Leading-zero blanking on and off.
    run(40, 16'h0050, 4'b1000, 4'b0000, 1'b1);
    run(40, 16'h0050, 4'b0000, 4'b0000, 1'b0);

    // Blink with fresh counter; split runs show it holds across idle.
    pulse_clr();
    run(48, 16'h1111, 4'b0001, 4'b0001, 1'b0);
    repeat (5) @(posedge CLK);
    run(144, 16'h1111, 4'b0001, 4'b0001, 1'b0);

    // EN drop during SHOW of digit 2, then re-enable.
    run(20, 16'h9876, 4'b0000, 4'b0000, 1'b0);
    run(40, 16'h9876, 4'b0000, 4'b0000, 1'b0);

    // Asynchronous CLR in the middle of a SHOW cycle.
    @(posedge CLK); #1;
    bus.DATA = 16'h2468; bus.DP = 4'b0011; bus.BLINK = 4'b0000; bus.LZB = 1'b0;
    bus.EN = 1'b1;
    s = cyc + 1;
    push_run(s, SCAN_DIV + 3, 16'h2468, 4'b0011, 4'b0000, 1'b0, 1'b0);
    repeat (SCAN_DIV + 4) @(posedge CLK);
    #2 CLR = 1'b1; bus.EN = 1'b0;
    frames_done = 0;
    #1;
    check("clr_async_sel", {28'd0, bus.SEL}, 32'hF);
    check("clr_async_seg", {25'd0, bus.SEG}, 32'h7F);
    check("clr_async_dp", {31'd0, bus.SEG_DP}, 32'h1);
    repeat (2) @(posedge CLK);
    #1 CLR = 1'b0;

    // Dash for a non-decimal nibble.
    run(40, 16'h000B, 4'b0000, 4'b0000, 1'b0);

    // Randomized runs.
    for (int k = 0; k < 12; k++) begin
      logic [15:0] d;
      d = 16'($urandom) & mask[$urandom_range(0, 3)];
      run($urandom_range(1, 140), d, 4'($urandom), 4'($urandom), 1'($urandom));
    end

    repeat (10) @(posedge CLK);
    #1;
    check("slot_queue_drained", slot_q.size(), 0);
    check("frame_queue_drained", frame_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
